// File: rtl/stage_three_if.sv
// stage_three_if -- memory bus between stage_three and the data memory.
//   mem_req   : access in progress (high for the whole ACCESS phase)
//   mem_we    : write strobe, qualifies mem_req for stores
//   mem_addr  : 16-bit word address
//   mem_wdata : 16-bit store data
//   mem_rdata : 16-bit load data, sampled on the ack cycle
//   mem_ack   : completion, one cycle
// master = stage_three, slave = memory.
interface stage_three_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stage_three.sv
// stage_three -- memory / writeback pipeline stage.
//
// Non-memory ops pass straight to the registered writeback ports one cycle
// after capture. Loads and stores latch their operands into hold registers and
// sit in ACCESS, holding the upstream pipe through mem_stall, until the memory
// acks. Loads then write the returned data to the destination register.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   halt_sys, stall      suppress capture; the stage emits a bubble
//   in_memc              00 none, 01 load, 10 store, 11 none
//   in_reg_wr, in_instr  destination write enable, [3:0] destination
//   in_alu               [15:0] result/address, [31:16] R0 value
//   in_R1_data, in_R0_en store data, R0 write enable
//   mem                  memory bus (stage_three_if.master)
//   mem_stall            upstream hold, high in every ACCESS cycle
//   wb_en/addr/data      register-file write port (registered)
//   wb_R0_en/wb_R0_data  R0 write port (registered)
//   mem_err              sticky access-timeout flag
//
// Build option: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// ACCESS cycles without ack. Without it, ACCESS waits indefinitely and mem_err
// is tied low.
module stage_three #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt_sys,
    input  logic                stall,
    input  logic [1:0]          in_memc,
    input  logic                in_reg_wr,
    input  logic [31:0]         in_alu,
    input  logic [15:0]         in_R1_data,
    input  logic                in_R0_en,
    input  logic [7:0]          in_instr,
    stage_three_if.master       mem,
    output logic                mem_stall,
    output logic                wb_en,
    output logic [3:0]          wb_addr,
    output logic [15:0]         wb_data,
    output logic                wb_R0_en,
    output logic [15:0]         wb_R0_data,
    output logic                mem_err
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [1:0] MEMC_LOAD  = 2'b01;
    localparam logic [1:0] MEMC_STORE = 2'b10;

    state_t state, state_nxt;

    logic        accept;     // IDLE and not held off: inputs are consumed this edge
    logic        is_mem_op;
    logic        timeout;    // last allowed ACCESS cycle passed without ack
    logic        in_access;

    logic [15:0] h_addr;
    logic [15:0] h_wdata;
    logic [3:0]  h_dest;
    logic        h_reg_wr;
    logic        h_store;

    assign in_access = (state == ACCESS);
    assign accept    = (state == IDLE) && !stall && !halt_sys;
    assign is_mem_op = (in_memc == MEMC_LOAD) || (in_memc == MEMC_STORE);

    // ------------------------------------------------------------------
    // Optional access timeout
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             unused_bits;

    // Fires in the TIMEOUT_CYCLES-th ACCESS cycle if no ack arrives; an ack
    // in that same cycle wins and completes normally.
    assign timeout = in_access && !mem.mem_ack &&
                     (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (!in_access)
            to_cnt <= '0;
        else if (!mem.mem_ack)
            to_cnt <= to_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_err <= 1'b0;
        else if (timeout)
            mem_err <= 1'b1;
    end

    assign unused_bits = ^in_instr[7:4];
`else
    logic unused_bits;

    assign timeout     = 1'b0;
    assign mem_err     = 1'b0;
    assign unused_bits = (^in_instr[7:4]) ^ (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem_op)      state_nxt = ACCESS;
            ACCESS:  if (mem.mem_ack || timeout)   state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Hold registers: loaded only when a memory op is accepted, so the bus
    // stays stable for the whole access regardless of upstream activity.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_addr   <= '0;
            h_wdata  <= '0;
            h_dest   <= '0;
            h_reg_wr <= 1'b0;
            h_store  <= 1'b0;
        end else if (accept && is_mem_op) begin
            h_addr   <= in_alu[15:0];
            h_wdata  <= in_R1_data;
            h_dest   <= in_instr[3:0];
            h_reg_wr <= in_reg_wr;
            h_store  <= (in_memc == MEMC_STORE);
        end
    end

    // Bus outputs decode from the state register, so an asynchronous reset
    // drops mem_req immediately.
    assign mem.mem_req   = in_access;
    assign mem.mem_we    = in_access && h_store;
    assign mem.mem_addr  = in_access ? h_addr  : 16'h0000;
    assign mem.mem_wdata = in_access ? h_wdata : 16'h0000;
    assign mem_stall     = in_access;

    // ------------------------------------------------------------------
    // Writeback registers. Enables default low every cycle (a bubble);
    // address/data only change when a real write is produced.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_R0_en   <= 1'b0;
            wb_R0_data <= '0;
        end else begin
            wb_en    <= 1'b0;
            wb_R0_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !is_mem_op) begin
                        wb_en      <= in_reg_wr;
                        wb_addr    <= in_instr[3:0];
                        wb_data    <= in_alu[15:0];
                        wb_R0_en   <= in_R0_en;
                        wb_R0_data <= in_alu[31:16];
                    end
                end
                ACCESS: begin
                    // Stores and timeouts leave the enables low.
                    if (mem.mem_ack && !h_store) begin
                        wb_en   <= h_reg_wr;
                        wb_addr <= h_dest;
                        wb_data <= mem.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_three.sv
module tb_stage_three;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_sys, stall, in_reg_wr, in_R0_en;
    logic [1:0]  in_memc;
    logic [31:0] in_alu;
    logic [15:0] in_R1_data;
    logic [7:0]  in_instr;
    logic        mem_stall, wb_en, wb_R0_en, mem_err;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data, wb_R0_data;

    stage_three_if mif ();

    stage_three #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt_sys   (halt_sys),
        .stall      (stall),
        .in_memc    (in_memc),
        .in_reg_wr  (in_reg_wr),
        .in_alu     (in_alu),
        .in_R1_data (in_R1_data),
        .in_R0_en   (in_R0_en),
        .in_instr   (in_instr),
        .mem        (mif.master),
        .mem_stall  (mem_stall),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_R0_en   (wb_R0_en),
        .wb_R0_data (wb_R0_data),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    // ---------------- behavioural model ----------------
    // Expected stage contents after the most recent clock edge.
    bit          m_busy, m_store, m_regwr, m_err;
    bit [15:0]   m_addr, m_wdata;
    bit [3:0]    m_dest;
    int          m_wait;
    bit          m_wb_en, m_r0_en;
    bit [3:0]    m_wb_addr;
    bit [15:0]   m_wb_data, m_r0_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_store = 0; m_regwr = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_dest = 0; m_wait = 0;
        m_wb_en = 0; m_r0_en = 0; m_wb_addr = 0; m_wb_data = 0; m_r0_data = 0;
    endtask

    // Apply the rules for one edge, given the inputs presently driven.
    task automatic model_step();
        if (!m_busy) begin
            if (stall || halt_sys) begin
                m_wb_en = 0; m_r0_en = 0;
            end else if (in_memc == 2'b01 || in_memc == 2'b10) begin
                m_busy  = 1;
                m_store = (in_memc == 2'b10);
                m_addr  = in_alu[15:0];
                m_wdata = in_R1_data;
                m_dest  = in_instr[3:0];
                m_regwr = in_reg_wr;
                m_wait  = 0;
                m_wb_en = 0; m_r0_en = 0;
            end else begin
                m_wb_en   = in_reg_wr;
                m_wb_addr = in_instr[3:0];
                m_wb_data = in_alu[15:0];
                m_r0_en   = in_R0_en;
                m_r0_data = in_alu[31:16];
            end
        end else begin
            m_wait++;
            if (mif.mem_ack) begin
                m_busy = 0; m_r0_en = 0;
                if (m_store) m_wb_en = 0;
                else begin
                    m_wb_en   = m_regwr;
                    m_wb_data = mif.mem_rdata;
                    m_wb_addr = m_dest;
                end
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_wait == TO) begin
                m_busy = 0; m_wb_en = 0; m_err = 1;
            end
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the model, and return just after
    // the following negedge (outputs of that edge are settled).
    task automatic apply(input logic h, input logic s, input logic [1:0] mc, input logic rw,
                         input logic [31:0] alu, input logic [15:0] r1, input logic r0,
                         input logic [7:0] ins, input logic ack, input logic [15:0] rd);
        halt_sys = h; stall = s; in_memc = mc; in_reg_wr = rw; in_alu = alu;
        in_R1_data = r1; in_R0_en = r0; in_instr = ins;
        mif.mem_ack = ack; mif.mem_rdata = rd;
        model_step();
        @(negedge clk); #1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on && rst) begin
            check("mem_req",    {31'b0, mif.mem_req}, {31'b0, m_busy});
            check("mem_stall",  {31'b0, mem_stall},   {31'b0, m_busy});
            if (m_busy) begin
                check("mem_we",    {31'b0, mif.mem_we}, {31'b0, m_store});
                check("mem_addr",  {16'b0, mif.mem_addr},  {16'b0, m_addr});
                check("mem_wdata", {16'b0, mif.mem_wdata}, {16'b0, m_wdata});
            end
            check("wb_en",      {31'b0, wb_en},      {31'b0, m_wb_en});
            check("wb_addr",    {28'b0, wb_addr},    {28'b0, m_wb_addr});
            check("wb_data",    {16'b0, wb_data},    {16'b0, m_wb_data});
            check("wb_R0_en",   {31'b0, wb_R0_en},   {31'b0, m_r0_en});
            check("wb_R0_data", {16'b0, wb_R0_data}, {16'b0, m_r0_data});
            check("mem_err",    {31'b0, mem_err},    {31'b0, m_err});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int stl;
        rst = 1'b0;
        halt_sys = 0; stall = 0; in_memc = 0; in_reg_wr = 0; in_alu = 0;
        in_R1_data = 0; in_R0_en = 0; in_instr = 0;
        mif.mem_ack = 0; mif.mem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", {31'b0, mif.mem_req}, 32'd0);
        check("rst_wb_en",   {31'b0, wb_en},       32'd0);
        check("rst_wb_data", {16'b0, wb_data},     32'd0);
        check("rst_mem_err", {31'b0, mem_err},     32'd0);
        rst = 1'b1;
        chk_on = 1;

        // ALU op passthrough
        apply(0, 0, 2'b00, 1, 32'h0001_0005, 16'h0, 1, 8'h03, 0, 16'h0);
        check("alu_wb_en",      {31'b0, wb_en},      32'd1);
        check("alu_wb_addr",    {28'b0, wb_addr},    32'd3);
        check("alu_wb_data",    {16'b0, wb_data},    32'h0005);
        check("alu_wb_R0_en",   {31'b0, wb_R0_en},   32'd1);
        check("alu_wb_R0_data", {16'b0, wb_R0_data}, 32'h0001);

        // Load at 0x0040, ack in the third ACCESS cycle; halt_sys and junk
        // inputs during the access must not disturb it.
        stl = 0;
        apply(0, 0, 2'b01, 1, 32'h0000_0040, 16'h0, 1, 8'h07, 0, 16'h0);
        check("ld_mem_addr", {16'b0, mif.mem_addr}, 32'h0040);
        check("ld_mem_we",   {31'b0, mif.mem_we},   32'd0);
        check("ld_wb_R0_en", {31'b0, wb_R0_en},     32'd0);
        stl += mem_stall;
        apply(1, 1, 2'b10, 0, 32'hFFFF_1111, 16'h5555, 1, 8'h0C, 0, 16'h0);
        stl += mem_stall;
        apply(1, 0, 2'b01, 0, 32'hAAAA_2222, 16'h6666, 1, 8'h0D, 0, 16'h0);
        stl += mem_stall;
        check("ld_addr_stable", {16'b0, mif.mem_addr}, 32'h0040);
        apply(1, 0, 2'b00, 0, 32'h0, 16'h0, 0, 8'h0, 1, 16'hBEEF);
        check("ld_stall_cycles", stl,                  32'd3);
        check("ld_stall_after",  {31'b0, mem_stall},   32'd0);
        check("ld_wb_en",        {31'b0, wb_en},       32'd1);
        check("ld_wb_data",      {16'b0, wb_data},     32'hBEEF);
        check("ld_wb_addr",      {28'b0, wb_addr},     32'd7);

        // Store 0x1234 at 0x0010, ack on the first ACCESS cycle
        apply(0, 0, 2'b10, 1, 32'h0000_0010, 16'h1234, 1, 8'h02, 0, 16'h0);
        check("st_mem_we",    {31'b0, mif.mem_we},     32'd1);
        check("st_mem_wdata", {16'b0, mif.mem_wdata},  32'h1234);
        check("st_mem_addr",  {16'b0, mif.mem_addr},   32'h0010);
        check("st_stall",     {31'b0, mem_stall},      32'd1);
        apply(0, 0, 2'b00, 0, 32'h0, 16'h0, 0, 8'h0, 1, 16'hDEAD);
        check("st_wb_en",     {31'b0, wb_en},          32'd0);
        check("st_stall_end", {31'b0, mem_stall},      32'd0);
        check("st_wb_data",   {16'b0, wb_data},        32'hBEEF);

        // Stall on a valid ALU op produces a bubble; ack in IDLE ignored
        apply(0, 1, 2'b00, 1, 32'h0009_0009, 16'h0, 1, 8'h05, 1, 16'h0);
        check("stl_wb_en",    {31'b0, wb_en},       32'd0);
        check("stl_wb_R0_en", {31'b0, wb_R0_en},    32'd0);
        check("stl_wb_data",  {16'b0, wb_data},     32'hBEEF);
        check("idle_ack_req", {31'b0, mif.mem_req}, 32'd0);

        // Reset in the middle of an access
        apply(0, 0, 2'b01, 1, 32'h0000_0022, 16'h0, 0, 8'h04, 0, 16'h0);
        apply(0, 0, 2'b00, 0, 32'h0, 16'h0, 0, 8'h0, 0, 16'h0);
        check("mid_req_before", {31'b0, mif.mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("arst_mem_req",   {31'b0, mif.mem_req}, 32'd0);
        check("arst_mem_stall", {31'b0, mem_stall},   32'd0);
        check("arst_wb_data",   {16'b0, wb_data},     32'd0);
        check("arst_wb_addr",   {28'b0, wb_addr},     32'd0);
        model_reset();
        @(negedge clk); #1;
        rst = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic ack;
            ack = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) == 0);
            apply($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                  16'($urandom), 1'($urandom), 8'($urandom), ack, 16'($urandom));
        end

        // Drain any access in flight
        for (int i = 0; i < 40 && m_busy; i++)
            apply(0, 0, 2'b00, 0, 32'h0, 16'h0, 0, 8'h0, 1, 16'h0);

`ifdef MEM_TIMEOUT_EN
        apply(0, 0, 2'b01, 1, 32'h0000_0033, 16'h0, 0, 8'h01, 0, 16'h0);
        for (int i = 0; i < TO; i++)
            apply(0, 0, 2'b00, 0, 32'h0, 16'h0, 0, 8'h0, 0, 16'h0);
        check("to_mem_err", {31'b0, mem_err},     32'd1);
        check("to_mem_req", {31'b0, mif.mem_req}, 32'd0);
        check("to_wb_en",   {31'b0, wb_en},       32'd0);
`endif

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_three.md
STAGE_THREE -- requirements
Module: stage_three

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles before abort (MEM_TIMEOUT_EN only).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 halt_sys  in  1  system halt; no new capture.
REQ-005 stall  in  1  hazard stall; current stage-B outputs are a bubble.
REQ-006 in_memc  in  2  memory op: 00 none, 01 load, 10 store, 11 treated as none.
REQ-007 in_reg_wr  in  1  destination register write enable.
REQ-008 in_alu  in  32  [15:0] result/address, [31:16] upper product/remainder.
REQ-009 in_R1_data  in  16  store data.
REQ-010 in_R0_en  in  1  write in_alu[31:16] to R0.
REQ-011 in_instr  in  8  top instruction byte; [3:0] destination register.
REQ-012 mem_req/mem_we  out  1/1  memory request, write strobe.
REQ-013 mem_addr/mem_wdata  out  16/16  address, write data.
REQ-014 mem_rdata/mem_ack  in  16/1  read data, completion.
REQ-015 mem_stall  out  1  upstream hold request.
REQ-016 wb_en/wb_addr/wb_data  out  1/4/16  register-file write port.
REQ-017 wb_R0_en/wb_R0_data  out  1/16  R0 write port.
REQ-018 mem_err  out  1  sticky timeout flag.

Function
REQ-019 FSM states IDLE, ACCESS; all wb_* outputs registered.
REQ-020 IDLE, stall=0, halt_sys=0, in_memc in {00,11}: next edge wb_en<=in_reg_wr, wb_addr<=in_instr[3:0], wb_data<=in_alu[15:0], wb_R0_en<=in_R0_en, wb_R0_data<=in_alu[31:16]; latency 1 cycle.
REQ-021 IDLE, stall=0, halt_sys=0, in_memc in {01,10}: next edge capture address, data, dest, reg_wr into hold registers, enter ACCESS, clear wb_en and wb_R0_en.
REQ-022 IDLE with stall=1 or halt_sys=1: next edge wb_en<=0, wb_R0_en<=0, other wb_* hold; no state change.
REQ-023 ACCESS: mem_req=1, mem_we=1 for store, mem_addr/mem_wdata from hold registers, stable until ack.
REQ-024 mem_stall=1 for every ACCESS cycle including the ack cycle; 0 in IDLE.
REQ-025 ACCESS with mem_ack=1: next edge return IDLE; load sets wb_en<=held reg_wr, wb_data<=mem_rdata, wb_addr<=held dest; store sets wb_en<=0; wb_R0_en<=0 for both.
REQ-026 Memory ops never write R0; in_R0_en ignored when in_memc in {01,10}.
REQ-027 halt_sys or stall during ACCESS does not abort the access; inputs are not sampled in ACCESS.
REQ-028 First input after ACCESS is accepted on the edge following the ack edge.
REQ-029 mem_ack in IDLE is ignored.

Reset
REQ-030 rst low: immediately state IDLE; all outputs 0; hold registers and timeout counter 0.
REQ-031 Reset during ACCESS drops mem_req asynchronously; transaction is abandoned.
REQ-032 Reset release takes effect on the first posedge with rst high.

Configuration
REQ-033 MEM_TIMEOUT_EN defined: counter increments each ACCESS cycle without ack; on reaching TIMEOUT_CYCLES, next edge IDLE, wb_en<=0, mem_err<=1 (held until reset).
REQ-034 Ack in the same cycle the count reaches TIMEOUT_CYCLES completes normally, no error.
REQ-035 MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_err tied 0.

Verification
REQ-036 ALU op in_alu=32'h0001_0005, reg_wr=1, instr[3:0]=3, R0_en=1 -> next cycle wb_en=1, wb_addr=3, wb_data=0005, wb_R0_en=1, wb_R0_data=0001.
REQ-037 Load addr 0x0040, ack after 3 cycles with rdata 0xBEEF -> mem_stall 3 cycles, then wb_en=1, wb_data=BEEF.
REQ-038 Store addr 0x0010, R1_data 0x1234, ack on 1st cycle -> mem_we=1, mem_wdata=1234, wb_en=0, mem_stall 1 cycle.
REQ-039 stall=1 on valid ALU op -> wb_en=0; halt_sys during load -> access still completes.
REQ-040 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> after 16 ACCESS cycles mem_err=1, IDLE, wb_en=0.
REQ-041 rst low mid-ACCESS -> mem_req=0 immediately, all outputs 0.
